// File: rtl/fft_spectrum_sink.sv
// fft_spectrum_sink
// Takes the FFT result stream, computes per-bin power re^2 + im^2 and stores
// each complete frame in a ping-pong spectrum buffer. It tracks the peak bin
// while the frame is being collected. The last committed frame is served
// through a 1-cycle-latency read port while the next frame fills the other bank.
//
// Ports
//   clk, rst          : system clock, synchronous active-high reset
//   real_in, imag_in  : signed bin value
//   fft_valid         : sample qualifier
//   fft_index         : bin number of the sample
//   overflow_in       : FFT overflow flag, sampled with fft_valid
//   rd_addr, rd_en    : random-access read request into the last committed frame
//   rd_data, rd_valid : read response, one cycle after rd_en
//   frame_done        : one-cycle pulse when a frame commits
//   peak_bin/power    : peak of the last committed frame (ties keep lowest bin)
//   frame_overflow    : overflow_in was seen in the last committed frame
//   frame_count       : number of committed frames (wraps)
//   index_error       : sticky out-of-sequence index flag
//
// state        | meaning
// ST_WAIT_START| discard samples until a bin-0 sample arrives
// ST_COLLECT   | accept consecutive bins, expecting r_expected next

module fft_spectrum_sink #(
  parameter int FFT_SIZE    = 256,
  parameter int DATA_WIDTH  = 24,
  parameter int INDEX_WIDTH = 12,
  parameter int POWER_WIDTH = 2*DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_WIDTH-1:0]  real_in,
  input  logic signed [DATA_WIDTH-1:0]  imag_in,
  input  logic                          fft_valid,
  input  logic        [INDEX_WIDTH-1:0] fft_index,
  input  logic                          overflow_in,
  input  logic        [INDEX_WIDTH-1:0] rd_addr,
  input  logic                          rd_en,
  output logic        [POWER_WIDTH-1:0] rd_data,
  output logic                          rd_valid,
  output logic                          frame_done,
  output logic        [INDEX_WIDTH-1:0] peak_bin,
  output logic        [POWER_WIDTH-1:0] peak_power,
  output logic                          frame_overflow,
  output logic        [15:0]            frame_count,
  output logic                          index_error
);

  localparam int                     LP_AW   = $clog2(FFT_SIZE);
  localparam logic [INDEX_WIDTH-1:0] LP_LAST = INDEX_WIDTH'(FFT_SIZE-1);
  localparam logic [INDEX_WIDTH:0]   LP_SIZE = (INDEX_WIDTH+1)'(FFT_SIZE);

  typedef enum logic {ST_WAIT_START, ST_COLLECT} state_t;

  state_t                   r_state;
  logic [INDEX_WIDTH-1:0]   r_expected;

  logic                     w_idx_zero;
  logic                     w_match;
  logic                     w_accept;
  logic                     w_last;

  logic signed [POWER_WIDTH-1:0] w_re_prod;
  logic signed [POWER_WIDTH-1:0] w_im_prod;

  // stage 1: squares
  logic                     r_s1_valid;
  logic                     r_s1_first;
  logic                     r_s1_last;
  logic                     r_s1_ovf;
  logic [INDEX_WIDTH-1:0]   r_s1_idx;
  logic [POWER_WIDTH-1:0]   r_s1_re2;
  logic [POWER_WIDTH-1:0]   r_s1_im2;

  // stage 2: power, RAM write, peak tracking
  logic                     r_s2_valid;
  logic                     r_s2_first;
  logic                     r_s2_last;
  logic                     r_s2_ovf;
  logic [INDEX_WIDTH-1:0]   r_s2_idx;
  logic [POWER_WIDTH-1:0]   r_s2_power;

  logic [INDEX_WIDTH-1:0]   r_run_bin;
  logic [POWER_WIDTH-1:0]   r_run_power;
  logic                     r_run_ovf;
  logic                     w_take_peak;
  logic [INDEX_WIDTH-1:0]   w_peak_bin;
  logic [POWER_WIDTH-1:0]   w_peak_power;
  logic                     w_ovf;

  // r_rd_bank is the bank holding the last committed frame; writes go to the other one
  logic                     r_rd_bank;
  logic                     r_frame_avail;

  logic [POWER_WIDTH-1:0]   r_mem [0:2*FFT_SIZE-1];

  // Sample acceptance. In COLLECT a bin-0 sample that breaks the sequence
  // still gets accepted as the start of a fresh frame.
  always_comb begin
    w_idx_zero = (fft_index == '0);
    w_match    = (r_state == ST_COLLECT) && (fft_index == r_expected);
    w_accept   = fft_valid && (w_match || w_idx_zero);
    w_last     = w_accept && (fft_index == LP_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_WAIT_START;
      r_expected  <= '0;
      index_error <= 1'b0;
    end else if (fft_valid) begin
      case (r_state)
        ST_WAIT_START: begin
          if (w_idx_zero) begin
            r_expected <= INDEX_WIDTH'(1);
            r_state    <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (w_match) begin
            if (fft_index == LP_LAST) r_state <= ST_WAIT_START;
            else                      r_expected <= r_expected + INDEX_WIDTH'(1);
          end else begin
            index_error <= 1'b1;
            if (w_idx_zero) r_expected <= INDEX_WIDTH'(1);
            else            r_state    <= ST_WAIT_START;
          end
        end
        default: r_state <= ST_WAIT_START;
      endcase
    end
  end

  // Squares are non-negative and fit in 2*DATA_WIDTH-1 bits, so the sum never wraps.
  assign w_re_prod = real_in * real_in;
  assign w_im_prod = imag_in * imag_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_ovf   <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_re2   <= '0;
      r_s1_im2   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_ovf   <= 1'b0;
      r_s2_idx   <= '0;
      r_s2_power <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_first <= w_accept && w_idx_zero;
      r_s1_last  <= w_last;
      r_s1_ovf   <= overflow_in;
      r_s1_idx   <= fft_index;
      r_s1_re2   <= w_re_prod;
      r_s1_im2   <= w_im_prod;
      r_s2_valid <= r_s1_valid;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      r_s2_ovf   <= r_s1_ovf;
      r_s2_idx   <= r_s1_idx;
      r_s2_power <= r_s1_re2 + r_s1_im2;
    end
  end

  always_ff @(posedge clk) begin
    if (r_s2_valid) r_mem[{~r_rd_bank, r_s2_idx[LP_AW-1:0]}] <= r_s2_power;
  end

  // Running peak including the sample currently in stage 2; bin 0 reloads it.
  always_comb begin
    w_take_peak  = r_s2_first || (r_s2_power > r_run_power);
    w_peak_bin   = w_take_peak ? r_s2_idx   : r_run_bin;
    w_peak_power = w_take_peak ? r_s2_power : r_run_power;
    w_ovf        = r_s2_first ? r_s2_ovf : (r_run_ovf | r_s2_ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_bin      <= '0;
      r_run_power    <= '0;
      r_run_ovf      <= 1'b0;
      r_rd_bank      <= 1'b0;
      r_frame_avail  <= 1'b0;
      frame_done     <= 1'b0;
      peak_bin       <= '0;
      peak_power     <= '0;
      frame_overflow <= 1'b0;
      frame_count    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (r_s2_valid) begin
        r_run_bin   <= w_peak_bin;
        r_run_power <= w_peak_power;
        r_run_ovf   <= w_ovf;
        if (r_s2_last) begin
          frame_done     <= 1'b1;
          peak_bin       <= w_peak_bin;
          peak_power     <= w_peak_power;
          frame_overflow <= w_ovf;
          frame_count    <= frame_count + 16'd1;
          r_rd_bank      <= ~r_rd_bank;
          r_frame_avail  <= 1'b1;
        end
      end
    end
  end

  // A read coinciding with a commit still sees the old r_rd_bank value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en && r_frame_avail;
      if (rd_en) begin
        if ({1'b0, rd_addr} >= LP_SIZE) rd_data <= '0;
        else                            rd_data <= r_mem[{r_rd_bank, rd_addr[LP_AW-1:0]}];
      end
    end
  end

endmodule
